// File: rtl/estufa_if.sv
// estufa_if: control/status bundle between a greenhouse supervisor (master) and estufa_ctrl (slave).
interface estufa_if #(
    parameter int NZONES = 2
);
    logic              enable;
    logic [NZONES-1:0] t1;
    logic [NZONES-1:0] t2;
    logic              clr_fault;
    logic [NZONES-1:0] heater;
    logic [NZONES-1:0] cooler;
    logic [NZONES-1:0] fault;
    logic              fault_any;
    modport master (output enable, t1, t2, clr_fault, input heater, cooler, fault, fault_any);
    modport slave  (input enable, t1, t2, clr_fault, output heater, cooler, fault, fault_any);
endinterface

// File: rtl/estufa_ctrl.sv
// estufa_ctrl: per-zone greenhouse heat/cool controller driven by two temperature thresholds.
// Define ESTUFA_DEBOUNCE_EN for the DEB_CYCLES debouncer; otherwise sensors pass one register stage.
module estufa_ctrl #(
    parameter int NZONES     = 2,
    parameter int DEB_CYCLES = 4,
    parameter int MIN_ON     = 8
) (
    input  logic    clk_2,
    input  logic    rst_n,
    estufa_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HEAT, COOL, FAULT} state_t;
    logic [NZONES-1:0] w_heater, w_cooler, w_fault;
    if (NZONES < 1 || NZONES > 8 || DEB_CYCLES < 2 || DEB_CYCLES > 255 || MIN_ON < 1 || MIN_ON > 255) begin : g_bad_param
        $error("estufa_ctrl: parameter out of range");
    end
    for (genvar g = 0; g < NZONES; g++) begin : g_zone
        logic [1:0] w_raw;
        logic [1:0] r_deb;
        logic [7:0] r_dwell;
        state_t     r_state;
        assign w_raw = {bus.t2[g], bus.t1[g]};
`ifdef ESTUFA_DEBOUNCE_EN
        logic [1:0] r_cand;
        logic [7:0] r_cnt;
        // r_cnt counts consecutive samples equal to r_cand; 0 means no candidate in flight
        always_ff @(posedge clk_2 or negedge rst_n)
            if (!rst_n) begin
                r_deb  <= 2'b01;
                r_cand <= 2'b01;
                r_cnt  <= '0;
            end else if (w_raw == r_deb) begin
                r_cnt  <= '0;
            end else if (w_raw != r_cand || r_cnt == '0) begin
                r_cand <= w_raw;
                r_cnt  <= 8'd1;
            end else if (r_cnt == 8'(DEB_CYCLES - 1)) begin
                r_deb  <= w_raw;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + 8'd1;
            end
`else
        always_ff @(posedge clk_2 or negedge rst_n)
            if (!rst_n) r_deb <= 2'b01;
            else        r_deb <= w_raw;
`endif
        // pair 10 (hot-only without cold) is physically impossible, so it wins over dwell and enable
        always_ff @(posedge clk_2 or negedge rst_n)
            if (!rst_n) begin
                r_state <= IDLE;
                r_dwell <= '0;
            end else begin
                case (r_state)
                    IDLE: if (bus.enable) begin
                        r_dwell <= 8'(MIN_ON);
                        r_state <= r_deb == 2'b00 ? HEAT : r_deb == 2'b11 ? COOL : r_deb == 2'b10 ? FAULT : IDLE;
                    end
                    HEAT, COOL: begin
                        r_dwell <= r_dwell == '0 ? '0 : r_dwell - 8'd1;
                        if (r_deb == 2'b10)
                            r_state <= FAULT;
                        else if (!bus.enable || (r_dwell == '0 && r_deb != (r_state == HEAT ? 2'b00 : 2'b11)))
                            r_state <= IDLE;
                    end
                    default: if (bus.clr_fault && r_deb != 2'b10) r_state <= IDLE;
                endcase
            end
        assign w_heater[g] = r_state == HEAT;
        assign w_cooler[g] = r_state == COOL;
        assign w_fault[g]  = r_state == FAULT;
    end
    assign bus.heater    = w_heater;
    assign bus.cooler    = w_cooler;
    assign bus.fault     = w_fault;
    assign bus.fault_any = |w_fault;
endmodule

// File: tb/tb_estufa_ctrl.sv
// tb_estufa_ctrl: table-driven check of estufa_ctrl with a scoreboard queue of expected outputs.
module tb_estufa_ctrl;
    localparam int NZ  = 2;
    localparam int DEB = 4;
    localparam int MON = 8;
`ifdef ESTUFA_DEBOUNCE_EN
    localparam int L = DEB + 1;
`else
    localparam int L = 2;
`endif
    typedef struct {
        logic       en;
        logic [1:0] p1;
        logic [1:0] p0;
        logic       clr;
        int         cyc;
        logic [1:0] h;
        logic [1:0] c;
        logic [1:0] f;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         total = 0;
    int         bad = 0;
    vec_t       tbl[$];
    logic [6:0] sb[$];
    estufa_if #(.NZONES(NZ)) bus();
    estufa_ctrl #(.NZONES(NZ), .DEB_CYCLES(DEB), .MIN_ON(MON)) dut (
        .clk_2(clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    function automatic logic [6:0] pk(input logic [1:0] h, input logic [1:0] c, input logic [1:0] f);
        return {|f, f, c, h};
    endfunction
    function automatic void add(input logic en, input logic [1:0] p1, input logic [1:0] p0, input logic clr,
                                input int cyc, input logic [1:0] h, input logic [1:0] c, input logic [1:0] f);
        vec_t v;
        v.en = en; v.p1 = p1; v.p0 = p0; v.clr = clr; v.cyc = cyc; v.h = h; v.c = c; v.f = f;
        tbl.push_back(v);
    endfunction
    task automatic drive(input logic en, input logic [1:0] p1, input logic [1:0] p0, input logic clr);
        bus.enable    = en;
        bus.t2        = {p1[1], p0[1]};
        bus.t1        = {p1[0], p0[0]};
        bus.clr_fault = clr;
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic check(input string name);
        logic [6:0] act;
        logic [6:0] exp;
        act = {bus.fault_any, bus.fault, bus.cooler, bus.heater};
        exp = sb.pop_front();
        total++;
        if (act !== exp || (bus.heater & bus.cooler) != '0) begin
            bad++;
            $display("FAIL %s: got {any,fault,cool,heat}=%b want %b", name, act, exp);
        end
    endtask
    initial begin
        add(1, 2'b01, 2'b01, 0, L + 1, 2'b00, 2'b00, 2'b00);
        add(1, 2'b01, 2'b00, 0, L - 1, 2'b00, 2'b00, 2'b00);
        add(1, 2'b01, 2'b00, 0, 1,     2'b01, 2'b00, 2'b00);
        add(1, 2'b01, 2'b01, 0, MON,   2'b01, 2'b00, 2'b00);
        add(1, 2'b01, 2'b01, 0, 1,     2'b00, 2'b00, 2'b00);
        add(1, 2'b01, 2'b11, 0, L,     2'b00, 2'b01, 2'b00);
        add(1, 2'b01, 2'b10, 0, L - 1, 2'b00, 2'b01, 2'b00);
        add(1, 2'b01, 2'b10, 0, 1,     2'b00, 2'b00, 2'b01);
        add(1, 2'b01, 2'b10, 1, 1,     2'b00, 2'b00, 2'b01);
        add(1, 2'b01, 2'b01, 0, L,     2'b00, 2'b00, 2'b01);
        add(1, 2'b01, 2'b01, 1, 1,     2'b00, 2'b00, 2'b00);
        add(1, 2'b10, 2'b00, 0, L,     2'b01, 2'b00, 2'b10);
        add(1, 2'b10, 2'b00, 0, 12,    2'b01, 2'b00, 2'b10);
        add(1, 2'b10, 2'b01, 0, L - 1, 2'b01, 2'b00, 2'b10);
        add(1, 2'b10, 2'b01, 0, 1,     2'b00, 2'b00, 2'b10);
        add(1, 2'b10, 2'b00, 0, L,     2'b01, 2'b00, 2'b10);
        add(0, 2'b10, 2'b00, 0, 1,     2'b00, 2'b00, 2'b10);
        add(0, 2'b10, 2'b00, 0, 3,     2'b00, 2'b00, 2'b10);
        add(1, 2'b10, 2'b00, 0, 1,     2'b01, 2'b00, 2'b10);
        drive(0, 2'b01, 2'b01, 0);
        #12;
        sb.push_back(pk(2'b00, 2'b00, 2'b00));
        check("reset_state");
        rst_n = 1'b1;
        tick(1);
`ifdef ESTUFA_DEBOUNCE_EN
        // zone1 glitching between 11 and 01 never holds long enough to be accepted
        for (int i = 0; i < 20; i++) begin
            drive(1, (i / 2) % 2 == 0 ? 2'b11 : 2'b01, 2'b01, 0);
            sb.push_back(pk(2'b00, 2'b00, 2'b00));
            tick(1);
            check($sformatf("glitch%0d", i));
        end
`endif
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].p1, tbl[i].p0, tbl[i].clr);
            sb.push_back(pk(tbl[i].h, tbl[i].c, tbl[i].f));
            tick(tbl[i].cyc);
            check($sformatf("vec%0d", i));
        end
        #3 rst_n = 1'b0;
        sb.push_back(pk(2'b00, 2'b00, 2'b00));
        #1 check("async_reset");
        #2 rst_n = 1'b1;
        sb.push_back(pk(2'b00, 2'b00, 2'b00));
        tick(L - 1);
        check("post_reset_hold");
        sb.push_back(pk(2'b01, 2'b00, 2'b10));
        tick(1);
        check("post_reset_resume");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
